// File: rtl/mem_block_mover_if.sv
// Job request and data-memory bus of the block mover.
// The mover takes the slave side. The requester and memory model take the master side.
interface mem_block_mover_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    // Job request, captured by the mover on the Start edge
    logic              Start;
    logic              Mode;
    logic [ADDR_W-1:0] SrcAddr;
    logic [ADDR_W-1:0] DstAddr;
    logic [ADDR_W-1:0] Length;
    logic [DATA_W-1:0] FillValue;

    // Job status
    logic              Busy;
    logic              Done;

    // Single-port data memory
    logic [ADDR_W-1:0] MemAddress;
    logic              MemRead;
    logic              MemWrite;
    logic [DATA_W-1:0] MemDataOut;
    logic [DATA_W-1:0] MemDataIn;

    modport slave (
        input  Start, Mode, SrcAddr, DstAddr, Length, FillValue, MemDataIn,
        output Busy, Done, MemAddress, MemRead, MemWrite, MemDataOut
    );

    modport master (
        output Start, Mode, SrcAddr, DstAddr, Length, FillValue, MemDataIn,
        input  Busy, Done, MemAddress, MemRead, MemWrite, MemDataOut
    );
endinterface

// File: rtl/mem_block_mover.sv
// Block copy / block fill engine in front of a single-port data memory.
// A copy moves one byte in two cycles: RD latches the byte, and WR stores it.
// A fill stores one byte per cycle.
// The copy runs in ascending order, so an overlapping copy with dst > src smears the first byte.
module mem_block_mover #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    mem_block_mover_if.slave   io_bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WR   = 3'd2,
        S_FILL = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic              r_mode;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_i;
    logic [DATA_W-1:0] r_fill;
    logic [DATA_W-1:0] r_hold;

    logic [ADDR_W-1:0] w_i_inc;
    logic              w_last;

    // The offset wraps with the address width, so base+offset wraps modulo memory depth.
    assign w_i_inc = r_i + 1'b1;
    assign w_last  = (w_i_inc == r_len);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (io_bus.Start) begin
                    if (io_bus.Length == '0) begin
                        w_state_next = S_DONE;
                    end else if (io_bus.Mode) begin
                        w_state_next = S_FILL;
                    end else begin
                        w_state_next = S_RD;
                    end
                end
            end
            S_RD:    w_state_next = S_WR;
            S_WR:    w_state_next = w_last ? S_DONE : S_RD;
            S_FILL:  w_state_next = w_last ? S_DONE : S_FILL;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Job parameters latch on Start, and the byte offset and read-hold register update
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mode <= 1'b0;
            r_src  <= '0;
            r_dst  <= '0;
            r_len  <= '0;
            r_fill <= '0;
            r_i    <= '0;
            r_hold <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io_bus.Start) begin
                        r_mode <= io_bus.Mode;
                        r_src  <= io_bus.SrcAddr;
                        r_dst  <= io_bus.DstAddr;
                        r_len  <= io_bus.Length;
                        r_fill <= io_bus.FillValue;
                        r_i    <= '0;
                    end
                end
                S_RD:         r_hold <= io_bus.MemDataIn;
                S_WR, S_FILL: r_i    <= w_i_inc;
                default:      ;
            endcase
        end
    end

    // Moore outputs: memory strobes, address and data are driven only in the active states
    always_comb begin
        io_bus.Busy       = 1'b0;
        io_bus.Done       = 1'b0;
        io_bus.MemRead    = 1'b0;
        io_bus.MemWrite   = 1'b0;
        io_bus.MemAddress = '0;
        io_bus.MemDataOut = '0;
        case (r_state)
            S_RD: begin
                io_bus.Busy       = 1'b1;
                io_bus.MemRead    = 1'b1;
                io_bus.MemAddress = r_src + r_i;
            end
            S_WR: begin
                io_bus.Busy       = 1'b1;
                io_bus.MemWrite   = 1'b1;
                io_bus.MemAddress = r_dst + r_i;
                io_bus.MemDataOut = r_hold;
            end
            S_FILL: begin
                io_bus.Busy       = 1'b1;
                io_bus.MemWrite   = 1'b1;
                io_bus.MemAddress = r_dst + r_i;
                io_bus.MemDataOut = r_fill;
            end
            S_DONE: begin
                io_bus.Done       = 1'b1;
            end
            default: ;
        endcase
    end

    // The mode bit is kept with the job for visibility. The state already encodes copy versus fill.
    logic w_unused;
    assign w_unused = r_mode;
endmodule

// File: tb/tb_mem_block_mover.sv
// Testbench for mem_block_mover. It runs directed jobs and random jobs against a byte-array reference memory.
`timescale 1ns/1ps
module tb_mem_block_mover;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 256;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_block_mover_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_block_mover #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .io_bus  (bus)
    );

    // Data memory model: a combinational read and a write on the clock edge, plus a bench preload port
    logic [7:0] mem     [DEPTH];
    logic [7:0] ref_mem [DEPTH];
    logic       pl_en;
    logic [7:0] pl_addr;
    logic [7:0] pl_data;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (bus.MemWrite) mem[bus.MemAddress] <= bus.MemDataOut;
    end
    assign bus.MemDataIn = bus.MemRead ? mem[bus.MemAddress] : 8'h00;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({bus.Busy, bus.Done, bus.MemRead, bus.MemWrite, bus.MemAddress, bus.MemDataOut});
    endfunction

    task automatic scramble_args();
        bus.Mode      = 1'($urandom);
        bus.SrcAddr   = 8'($urandom);
        bus.DstAddr   = 8'($urandom);
        bus.Length    = 8'($urandom);
        bus.FillValue = 8'($urandom);
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        ref_mem[a] = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic check_mem(input string tag);
        int diffs;
        diffs = 0;
        for (int a = 0; a < DEPTH; a++) if (mem[a] !== ref_mem[a]) diffs++;
        check({tag, ".mem_diffs"}, 32'(diffs), 32'd0);
    endtask

    // Runs one job. The call begins one clock edge after the previous job ended.
    // disturb is the cycle number in which a spurious Start is pulsed, or 0 for none.
    // rst_cycle is the cycle number in which reset is asserted, or 0 for none.
    task automatic run_job(input string name, input logic mode, input logic [7:0] src,
                           input logic [7:0] dst, input logic [7:0] len, input logic [7:0] fill,
                           input int disturb, input int rst_cycle);
        int busy_n, nwr, last_c, k;
        logic [7:0] wd [256];
        logic e_busy, e_done, e_rd, e_wr;
        logic [7:0] e_addr, e_dout;

        busy_n = (len == 0) ? 0 : (mode ? int'(len) : 2 * int'(len));
        nwr = int'(len);
        if (rst_cycle > 0) begin
            k = mode ? rst_cycle : rst_cycle / 2;
            if (k < nwr) nwr = k;
        end
        // Reference model: the bytes go in ascending order, and each read sees the earlier writes
        for (int j = 0; j < nwr; j++) begin
            wd[j] = mode ? fill : ref_mem[8'(src + 8'(j))];
            ref_mem[8'(dst + 8'(j))] = wd[j];
        end

        // Start cycle: the outputs are still idle
        bus.Start = 1'b1; bus.Mode = mode; bus.SrcAddr = src; bus.DstAddr = dst;
        bus.Length = len; bus.FillValue = fill;
        @(negedge clk);
        check({name, ".idle_at_start"}, out_vec(), 32'd0);
        @(posedge clk); #1;

        last_c = (rst_cycle > 0) ? rst_cycle + 3 : busy_n + 1;
        for (int c = 1; c <= last_c; c++) begin
            scramble_args();
            bus.Start = (c == disturb);
            rst = (c == rst_cycle);
            @(negedge clk);
            e_busy = 1'b0; e_done = 1'b0; e_rd = 1'b0; e_wr = 1'b0; e_addr = 8'h00; e_dout = 8'h00;
            if (!(rst_cycle > 0 && c > rst_cycle)) begin
                e_busy = (c <= busy_n);
                e_done = (c == busy_n + 1);
                if (c <= busy_n) begin
                    if (mode) begin
                        k = c - 1;
                        e_wr = 1'b1; e_addr = 8'(dst + 8'(k)); e_dout = wd[k];
                    end else begin
                        k = (c - 1) / 2;
                        if (c % 2 == 1) begin
                            e_rd = 1'b1; e_addr = 8'(src + 8'(k));
                        end else begin
                            e_wr = 1'b1; e_addr = 8'(dst + 8'(k)); e_dout = wd[k];
                        end
                    end
                end
            end
            check($sformatf("%s.c%0d.busy", name, c), 32'(bus.Busy), 32'(e_busy));
            check($sformatf("%s.c%0d.done", name, c), 32'(bus.Done), 32'(e_done));
            check($sformatf("%s.c%0d.rd", name, c), 32'(bus.MemRead), 32'(e_rd));
            check($sformatf("%s.c%0d.wr", name, c), 32'(bus.MemWrite), 32'(e_wr));
            check($sformatf("%s.c%0d.addr", name, c), 32'(bus.MemAddress), 32'(e_addr));
            check($sformatf("%s.c%0d.dout", name, c), 32'(bus.MemDataOut), 32'(e_dout));
            @(posedge clk); #1;
        end
        bus.Start = 1'b0;
        rst = 1'b0;
        check_mem(name);
        $display("job %s mode=%0d src=%02h dst=%02h len=%0d fill=%02h disturb=%0d rst=%0d compared=%0d mismatched=%0d",
                 name, mode, src, dst, len, fill, disturb, rst_cycle, n_cmp, n_fail);
    endtask

    task automatic gap();
        @(posedge clk); #1;
    endtask

    initial begin
        logic       m;
        logic [7:0] s, d, l, f;
        int         dis, bn;

        rst = 1'b1; pl_en = 1'b0; pl_addr = 8'h00; pl_data = 8'h00;
        bus.Start = 1'b0; scramble_args();
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset.outputs", out_vec(), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int a = 0; a < DEPTH; a++) preload(8'(a), 8'($urandom));

        // Copy of 4 bytes
        preload(8'h10, 8'hA1); preload(8'h11, 8'hB2); preload(8'h12, 8'hC3); preload(8'h13, 8'hD4);
        run_job("copy4", 1'b0, 8'h10, 8'h40, 8'd4, 8'h00, 0, 0);
        check("copy4.m40", 32'(mem[8'h40]), 32'hA1);
        check("copy4.m43", 32'(mem[8'h43]), 32'hD4);
        gap();

        // Fill that wraps from the top of memory to address 0
        run_job("fill_wrap", 1'b1, 8'h00, 8'hFE, 8'd4, 8'h5A, 0, 0);
        check("fill_wrap.m01", 32'(mem[8'h01]), 32'h5A);
        gap();

        // Zero-length job
        run_job("len0", 1'b0, 8'h33, 8'h66, 8'd0, 8'h00, 0, 0);
        gap();

        // A Start pulsed while the job is busy is ignored
        run_job("start_busy", 1'b0, 8'h05, 8'hC0, 8'd3, 8'h00, 2, 0);
        gap();

        // Reset asserted mid-copy
        run_job("rst_mid", 1'b0, 8'h20, 8'h80, 8'd8, 8'h00, 0, 5);
        gap();

        // Overlapping copy smears the first byte upward
        preload(8'h00, 8'h01); preload(8'h01, 8'h02); preload(8'h02, 8'h03); preload(8'h03, 8'h04);
        run_job("overlap", 1'b0, 8'h00, 8'h01, 8'd3, 8'h00, 0, 0);
        check("overlap.m03", 32'(mem[8'h03]), 32'h01);
        gap();

        // Back-to-back: the copy Start lands in the idle cycle right after Done
        run_job("b2b_fill", 1'b1, 8'h00, 8'hA0, 8'd5, 8'h77, 0, 0);
        run_job("b2b_copy", 1'b0, 8'hA0, 8'hB0, 8'd5, 8'h00, 0, 0);
        check("b2b.mB4", 32'(mem[8'hB4]), 32'h77);
        gap();

        // Random jobs
        for (int t = 0; t < 40; t++) begin
            m = 1'($urandom);
            s = 8'($urandom);
            d = 8'($urandom);
            f = 8'($urandom);
            l = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
            bn = (l == 0) ? 0 : (m ? int'(l) : 2 * int'(l));
            dis = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, bn + 1)) : 0;
            run_job($sformatf("rnd%0d", t), m, s, d, l, f, dis, 0);
            if ($urandom_range(0, 1) == 1) gap();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
